imm_extend_unit: RTL
====================

// Module: imm_extend_unit
// PURPOSE
//  Registered, parametrised immediate-extension stage for the pipelined datapath.
//  Takes raw instruction immediates from decode.
//  Produces WORD_W-bit operands in one of four modes: zero, sign, upper, branch-offset.
//  Sits between decode and the ID/EX latch with a valid/ready handshake.
//  A 2-entry skid buffer lets a downstream stall propagate one cycle late.
//  No operand is lost and the path never combinationally blocks.
// PARAMETERS
//  IMM_W     16  raw immediate width; must satisfy 1 <= IMM_W < WORD_W
//  WORD_W    32  output operand width (cpu_types_pkg::word_t when 32)
//  BR_SHIFT  2   left shift applied in branch mode; 0 <= BR_SHIFT < WORD_W
// PORTS
//  CLK        in   1        rising-edge clock
//  RST        in   1        asynchronous, active-high reset
//  flush      in   1        synchronous pipeline flush (squash all held operands)
//  in_valid   in   1        upstream presents in_imm/in_mode
//  in_ready   out  1        unit can accept this cycle
//  in_imm     in   IMM_W    raw immediate
//  in_mode    in   3        000 zero, 001 sign, 010 upper, 011 branch, 1xx illegal
//  out_valid  out  1        out_imm/out_err valid
//  out_ready  in   1        downstream accepts this cycle
//  out_imm    out  WORD_W   extended operand
//  out_err    out  1        operand came from an illegal mode
// BEHAVIOUR
//  Extension (computed on accept, registered):
//   zero:   {(WORD_W-IMM_W)'0, imm}
//   sign:   {(WORD_W-IMM_W){imm[IMM_W-1]}, imm}
//   upper:  imm placed in bits [WORD_W-1 -: IMM_W], low bits 0.
//           If IMM_W < WORD_W/2 the value is still left-justified.
//   branch: sign-extended value << BR_SHIFT; MSBs shifted out are dropped.
//   1xx:    out_imm = 0, out_err = 1. All legal modes give out_err = 0.
//  Storage: output reg (O) + skid reg (S), each with a valid bit.
//  States:
//   EMPTY  !O.v, !S.v
//   ONE    O.v, !S.v
//   TWO    O.v, S.v
//  Handshake:
//   in_ready = !S.v (registered, no comb path from out_ready).
//   accept = in_valid & in_ready.
//   out_valid = O.v; out_imm/out_err driven from O only.
//   Output transfer = out_valid & out_ready.
//   out_imm/out_err hold stable while out_valid & !out_ready.
//  Transitions (no flush):
//   EMPTY + accept -> ONE (O <= new).
//   ONE + accept + transfer -> ONE (O <= new).
//   ONE + accept + !transfer -> TWO (S <= new).
//   ONE + !accept + transfer -> EMPTY.
//   TWO + transfer -> ONE (O <= S). in_ready is 0 in TWO, so no accept.
//   Other combinations hold state.
//  Latency: accept in cycle N -> out_valid in N+1 when EMPTY/draining.
//  Order: strictly FIFO.
//  flush=1 at a rising edge:
//   O.v, S.v <- 0; the state is EMPTY next cycle.
//   Any accept in that same cycle is discarded.
//   in_ready is 1 the following cycle.
//   Flush wins over accept and transfer.
//  Reset:
//   Async assert clears O.v, S.v, out_imm = 0, out_err = 0.
//   out_valid = 0 immediately; in_ready = 1 after release.
//   Reset mid-transfer drops all held operands; there is no partial output.
//  Data regs: load only on accept/shift. Valid bits alone define occupancy.
// TESTING
//  1. Reset, then mode 001, imm 16'h8004, out_ready=1.
//     -> out_valid next cycle, out_imm 32'hFFFF8004, out_err 0.
//  2. Modes 000/010/011 with imm 16'hFFFC.
//     -> 32'h0000FFFC / 32'hFFFC0000 / 32'hFFFFFFF0.
//     Mode 101 -> out_imm 0, out_err 1.
//  3. Stream A,B,C back-to-back; out_ready=0 for 3 cycles.
//     -> in_ready drops after B is held in S; output holds A stable.
//     -> After release: A, B, C in order with no loss or duplicate.
//  4. In TWO state, assert flush with in_valid=1.
//     -> out_valid 0 next cycle, in_ready 1, flushed input never appears.
//  5. Assert RST asynchronously mid-cycle while TWO.
//     -> out_valid, out_imm, out_err go 0 before the next edge.
//     -> After release the first accepted imm appears alone.
//  6. Re-run 1-3 with IMM_W=8, WORD_W=16, BR_SHIFT=1.
//     -> sign 8'h80 -> 16'hFF80; branch 8'h81 -> 16'hFF02.

Source files
------------

// File: rtl/imm_extend_unit.sv
// Registered immediate-extension stage (zero/sign/upper/branch) with a valid/ready
// handshake and a two-entry output/skid buffer so downstream stalls land one cycle late.
//
// state | meaning
// EMPTY | no operand held; in_ready=1, out_valid=0
// ONE   | operand in output reg only; in_ready=1, out_valid=1
// TWO   | output reg and skid reg both full; in_ready=0, out_valid=1
module imm_extend_unit #(
  parameter int IMM_W    = 16,
  parameter int WORD_W   = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [2:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_imm,
  output logic              out_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  state_t state, state_nxt;

  logic [WORD_W-1:0] sign_ext;
  logic [WORD_W-1:0] ext_imm;
  logic              ext_err;
  logic [WORD_W-1:0] o_imm, s_imm;
  logic              o_err, s_err;
  logic              accept, transfer;
  logic              load_o_new, load_o_skid, load_s;

  assign sign_ext = {{(WORD_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};

  always_comb begin
    ext_imm = '0;
    ext_err = 1'b0;
    if (in_mode[2]) begin
      ext_err = 1'b1;
    end else begin
      case (in_mode[1:0])
        2'b00:   ext_imm = {{(WORD_W-IMM_W){1'b0}}, in_imm};
        2'b01:   ext_imm = sign_ext;
        2'b10:   ext_imm = {in_imm, {(WORD_W-IMM_W){1'b0}}};
        default: ext_imm = sign_ext << BR_SHIFT;
      endcase
    end
  end

  // in_ready comes straight from the state register, so out_ready never gates it combinationally
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign transfer  = out_valid & out_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    load_o_new  = 1'b0;
    load_o_skid = 1'b0;
    load_s      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt  = ONE;
          load_o_new = 1'b1;
        end
      end
      ONE: begin
        if (accept && transfer) begin
          load_o_new = 1'b1;
        end else if (accept) begin
          state_nxt = TWO;
          load_s    = 1'b1;
        end else if (transfer) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (transfer) begin
          state_nxt   = ONE;
          load_o_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // flush beats both accept and transfer; whatever was in flight is squashed
    if (flush) begin
      state_nxt   = EMPTY;
      load_o_new  = 1'b0;
      load_o_skid = 1'b0;
      load_s      = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      o_imm <= '0;
      o_err <= 1'b0;
      s_imm <= '0;
      s_err <= 1'b0;
    end else begin
      if (load_o_new) begin
        o_imm <= ext_imm;
        o_err <= ext_err;
      end else if (load_o_skid) begin
        o_imm <= s_imm;
        o_err <= s_err;
      end
      if (load_s) begin
        s_imm <= ext_imm;
        s_err <= ext_err;
      end
    end
  end

  assign out_imm = o_imm;
  assign out_err = o_err;

endmodule
